imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-port, 64-word instruction memory (async read, sync write) between the core's fetch stage and a debug/program loader port. Fixed loader priority is bounded by an anti-starvation counter that guarantees fetch a grant. Each granted request gets a registered response one cycle later. The block sits between the fetch unit and loader on one side and the imem instance on the other.

## Interface
- MAX_STREAK, default 4: maximum consecutive loader grants while fetch is waiting; legal range 1..15.
- clk  in  1  system clock; all state is captured on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch request valid.
- f_ready  out  1  fetch request granted this cycle (combinational).
- f_addr  in  32  fetch byte address (PC).
- f_resp_valid  out  1  fetch response valid, one-cycle pulse.
- f_resp_data  out  32  fetched instruction.
- f_resp_err  out  1  misaligned fetch (f_addr[1:0] != 0).
- l_valid  in  1  loader request valid.
- l_ready  out  1  loader request granted this cycle (combinational).
- l_we  in  1  loader write enable (1 = write, 0 = read).
- l_addr  in  6  loader word address.
- l_wdata  in  32  loader write data.
- l_resp_valid  out  1  loader response valid, one-cycle pulse, sent for reads and writes.
- l_resp_data  out  32  read data, or echo of written data for writes.
- mem_addr  out  6  word address to imem.
- mem_we  out  1  imem write enable.
- mem_wdata  out  32  imem write data.
- mem_rdata  in  32  imem asynchronous read data.

## Operation
- Grant is combinational each cycle and selects one of NONE, FETCH or LOAD.
  - If only one port is valid, that port is granted.
  - If both are valid, LOAD is granted unless streak == MAX_STREAK, in which case FETCH is granted.
- streak is a 4-bit counter.
  - Increments on each LOAD grant while f_valid is high.
  - Clears on any FETCH grant, or in any cycle with f_valid low.
  - Saturates at MAX_STREAK.
- Memory port mux:
  - FETCH grant: mem_addr = f_addr[7:2], mem_we = 0. f_addr[31:8] is ignored, so addresses wrap modulo 256 bytes.
  - LOAD grant: mem_addr = l_addr, mem_we = l_we, mem_wdata = l_wdata.
  - NONE: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- A misaligned fetch is still granted and consumes the slot. The read is performed as normal and f_resp_err = 1.
- mem_we is forced to 0 whenever reset_n is low.
- Requesters must hold valid and payload stable until ready is seen. The block does not require this for correctness.
- Responses cannot be backpressured; requesters always accept them.

## Timing
- Reset values: f_resp_valid, l_resp_valid, f_resp_err = 0; f_resp_data, l_resp_data = 0; streak = 0.
- Cycle N, request granted: mem_rdata (or l_wdata for a write) is captured at the end of cycle N.
- Cycle N+1: resp_valid is high with that data for exactly one cycle. Latency is 1.
- Throughput is one grant per cycle in total. Back-to-back grants to the same port give consecutive response pulses.
- A loader write at N followed by a read of the same address at N+1 returns the new data, because the write commits at edge N.
- With both ports continuously valid, the pattern is MAX_STREAK LOAD grants then 1 FETCH grant, repeating.
- Async reset mid-operation:
  - Clears responses and streak immediately.
  - A request granted in the reset cycle produces no response and no write.
- f_valid dropping during a streak resets streak to 0 at the next edge.

## Structure
- Package imem_arb_pkg holds:
  - IMEM_AW = 6.
  - Typedef enum logic [1:0] grant_t {GNT_NONE, GNT_FETCH, GNT_LOAD}.
  - Function imem_word_addr(byte address) returning bits [7:2].
- One sub-module, imem_arb_resp: a per-port response register (valid, data, err), instantiated twice. The loader instance ties err to 0.
- Top level holds the streak counter, grant logic and memory mux.

## Test plan
- Reset mid-stream: assert reset_n = 0 while LOAD is granted with l_we = 1 → mem_we = 0 immediately, the memory word is unchanged, resp_valid = 0 in the following cycle, and streak = 0.
- Single-port fetch: f_addr = 0x0000_0008 with only f_valid → f_ready = 1 in cycle N; cycle N+1 has f_resp_valid = 1 and f_resp_data = RAM[2].
- Write then read: loader writes 0xDEAD_BEEF to word 5, then reads word 5 the next cycle → l_resp_data = 0xDEAD_BEEF, then 0xDEAD_BEEF, with two consecutive pulses.
- Contention with MAX_STREAK = 4 and both ports valid for 10 cycles → grant sequence L,L,L,L,F,L,L,L,L,F.
- Misaligned fetch: f_addr = 0x0000_0006 → f_resp_err = 1 and f_resp_data = RAM[1]. A following f_addr = 0x0000_0104 returns RAM[1] (wrap) with f_resp_err = 0.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arb_pkg;

    localparam int IMEM_AW = 6;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_LOAD  = 2'd2
    } grant_t;

    // Byte address to imem word index; upper bits are dropped so fetches wrap at 256 bytes.
    function automatic logic [IMEM_AW-1:0] imem_word_addr(input logic [31:0] byte_addr);
        return byte_addr[7:2];
    endfunction

endpackage

// File: rtl/imem_arb_resp.sv
// One-cycle response register for a single arbiter port.
module imem_arb_resp (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture,
    input  logic [31:0] data_in,
    input  logic        err_in,
    output logic        valid,
    output logic [31:0] data,
    output logic        err
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            err   <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                data <= data_in;
                err  <= err_in;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port imem between fetch and loader, with loader priority
// bounded by a streak counter so a waiting fetch is always eventually granted.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                f_valid,
    output logic                f_ready,
    input  logic [31:0]         f_addr,
    output logic                f_resp_valid,
    output logic [31:0]         f_resp_data,
    output logic                f_resp_err,
    input  logic                l_valid,
    output logic                l_ready,
    input  logic                l_we,
    input  logic [IMEM_AW-1:0]  l_addr,
    input  logic [31:0]         l_wdata,
    output logic                l_resp_valid,
    output logic [31:0]         l_resp_data,
    output logic [IMEM_AW-1:0]  mem_addr,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    grant_t     grant;
    logic [3:0] streak;
    logic       l_err;
    logic       unused_l_err;

    always_comb begin
        grant = GNT_NONE;
        if (f_valid && l_valid) begin
            grant = (streak == STREAK_MAX) ? GNT_FETCH : GNT_LOAD;
        end else if (f_valid) begin
            grant = GNT_FETCH;
        end else if (l_valid) begin
            grant = GNT_LOAD;
        end
    end

    assign f_ready = (grant == GNT_FETCH);
    assign l_ready = (grant == GNT_LOAD);

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (grant)
            GNT_FETCH: mem_addr = imem_word_addr(f_addr);
            GNT_LOAD: begin
                mem_addr  = l_addr;
                mem_we    = l_we && reset_n;
                mem_wdata = l_wdata;
            end
            default: ;
        endcase
    end

    // Streak only counts loader wins while fetch is actually waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
        end else if (!f_valid || grant == GNT_FETCH) begin
            streak <= '0;
        end else if (grant == GNT_LOAD && streak != STREAK_MAX) begin
            streak <= streak + 4'd1;
        end
    end

    imem_arb_resp u_f_resp (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (f_ready),
        .data_in (mem_rdata),
        .err_in  (f_addr[1:0] != 2'b00),
        .valid   (f_resp_valid),
        .data    (f_resp_data),
        .err     (f_resp_err)
    );

    // Loader writes echo their own write data back.
    imem_arb_resp u_l_resp (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (l_ready),
        .data_in (l_we ? l_wdata : mem_rdata),
        .err_in  (1'b0),
        .valid   (l_resp_valid),
        .data    (l_resp_data),
        .err     (l_err)
    );

    assign unused_l_err = l_err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table plus response scoreboard.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_valid = 1'b0, f_ready, f_resp_valid, f_resp_err;
    logic [31:0] f_addr = '0, f_resp_data;
    logic        l_valid = 1'b0, l_ready, l_we = 1'b0, l_resp_valid;
    logic [5:0]  l_addr = '0;
    logic [31:0] l_wdata = '0, l_resp_data;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter #(.MAX_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data), .f_resp_err(f_resp_err),
        .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_resp_valid(l_resp_valid), .l_resp_data(l_resp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // imem model: async read, sync write; loaded on the first edge while reset is held
    logic [31:0] ram [64];
    logic        loaded = 1'b0;
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        lv;
        logic        lwe;
        logic [5:0]  la;
        logic [31:0] lwd;
        grant_t      g;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } resp_t;

    vec_t        tbl[$];
    resp_t       fq[$];
    resp_t       lq[$];
    logic [31:0] model [64];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic lv,
                                input logic lwe, input logic [5:0] la, input logic [31:0] lwd,
                                input grant_t g);
        vec_t v;
        v.fv = fv; v.fa = fa; v.lv = lv; v.lwe = lwe; v.la = la; v.lwd = lwd; v.g = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_resps();
        resp_t r;
        if (fq.size() > 0) begin
            r = fq.pop_front();
            chk("f_resp_valid", 32'(f_resp_valid), 32'd1);
            chk("f_resp_data", f_resp_data, r.d);
            chk("f_resp_err", 32'(f_resp_err), 32'(r.e));
        end else begin
            chk("f_resp_valid_idle", 32'(f_resp_valid), 32'd0);
        end
        if (lq.size() > 0) begin
            r = lq.pop_front();
            chk("l_resp_valid", 32'(l_resp_valid), 32'd1);
            chk("l_resp_data", l_resp_data, r.d);
        end else begin
            chk("l_resp_valid_idle", 32'(l_resp_valid), 32'd0);
        end
    endtask

    // Called at posedge+1: drive, check grant/mux mid-cycle, then check responses after the edge.
    task automatic step(input vec_t v);
        resp_t r;
        f_valid = v.fv; f_addr = v.fa;
        l_valid = v.lv; l_we = v.lwe; l_addr = v.la; l_wdata = v.lwd;
        #3;
        chk("grant", {30'd0, f_ready, l_ready},
            {30'd0, v.g == GNT_FETCH, v.g == GNT_LOAD});
        case (v.g)
            GNT_FETCH: begin
                chk("mem_addr_f", 32'(mem_addr), 32'(v.fa[7:2]));
                chk("mem_we_f", 32'(mem_we), 32'd0);
                r.d = model[v.fa[7:2]];
                r.e = (v.fa[1:0] != 2'b00);
                fq.push_back(r);
            end
            GNT_LOAD: begin
                chk("mem_addr_l", 32'(mem_addr), 32'(v.la));
                chk("mem_we_l", 32'(mem_we), 32'(v.lwe));
                if (v.lwe) chk("mem_wdata_l", mem_wdata, v.lwd);
                r.d = v.lwe ? v.lwd : model[v.la];
                r.e = 1'b0;
                lq.push_back(r);
                if (v.lwe) model[v.la] = v.lwd;
            end
            default: begin
                chk("mem_addr_none", 32'(mem_addr), 32'd0);
                chk("mem_we_none", 32'(mem_we), 32'd0);
                chk("mem_wdata_none", mem_wdata, 32'd0);
            end
        endcase
        @(posedge clk);
        #1;
        check_resps();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) model[i] = init_word(i);

        // idle and single-port cases, write-then-read, misaligned and wrapping fetch
        tbl.push_back(mk(0, 32'h0,   0, 0, 6'd0, 32'h0,         GNT_NONE));
        tbl.push_back(mk(1, 32'h8,   0, 0, 6'd0, 32'h0,         GNT_FETCH));
        tbl.push_back(mk(0, 32'h0,   1, 1, 6'd5, 32'hDEADBEEF,  GNT_LOAD));
        tbl.push_back(mk(0, 32'h0,   1, 0, 6'd5, 32'h0,         GNT_LOAD));
        tbl.push_back(mk(1, 32'h6,   0, 0, 6'd0, 32'h0,         GNT_FETCH));
        tbl.push_back(mk(1, 32'h104, 0, 0, 6'd0, 32'h0,         GNT_FETCH));
        tbl.push_back(mk(0, 32'h0,   0, 0, 6'd0, 32'h0,         GNT_NONE));
        // contention: L,L,L,L,F,L,L,L,L,F
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 32'h10, 1, 0, 6'(i + 10), 32'h0,
                             (i == 4 || i == 9) ? GNT_FETCH : GNT_LOAD));
        tbl.push_back(mk(1, 32'h0C,  0, 0, 6'd0, 32'h0,         GNT_FETCH));
        tbl.push_back(mk(1, 32'hFC,  1, 1, 6'd9, 32'h12345678,  GNT_LOAD));
        tbl.push_back(mk(0, 32'h0,   1, 0, 6'd9, 32'h0,         GNT_LOAD));
        // streak cleared by f_valid dropping mid-streak
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 32'h20, 1, 0, 6'(i), 32'h0, GNT_LOAD));
        tbl.push_back(mk(0, 32'h20,  1, 0, 6'd3, 32'h0,         GNT_LOAD));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 32'h20, 1, 0, 6'(i + 40), 32'h0, GNT_LOAD));
        tbl.push_back(mk(1, 32'h24,  1, 0, 6'd44, 32'h0,        GNT_FETCH));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_f_resp_valid", 32'(f_resp_valid), 32'd0);
        chk("rst_l_resp_valid", 32'(l_resp_valid), 32'd0);
        chk("rst_f_resp_err", 32'(f_resp_err), 32'd0);
        chk("rst_f_resp_data", f_resp_data, 32'd0);
        chk("rst_l_resp_data", l_resp_data, 32'd0);
        reset_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // reset asserted during a granted loader write
        for (int i = 0; i < 3; i++) step(mk(1, 32'h10, 1, 0, 6'(i), 32'h0, GNT_LOAD));
        f_valid = 1'b1; f_addr = 32'h10;
        l_valid = 1'b1; l_we = 1'b1; l_addr = 6'd20; l_wdata = 32'hBAD0_BAD0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mid_l_resp_valid", 32'(l_resp_valid), 32'd0);
        chk("rst_mid_f_resp_valid", 32'(f_resp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid_l_resp_after", 32'(l_resp_valid), 32'd0);
        chk("rst_mid_f_resp_after", 32'(f_resp_valid), 32'd0);
        chk("rst_mid_ram20", ram[20], model[20]);
        reset_n = 1'b1;
        // streak restarted from zero: four loader wins before fetch
        for (int i = 0; i < 5; i++)
            step(mk(1, 32'h14, 1, 0, 6'd20, 32'h0, (i == 4) ? GNT_FETCH : GNT_LOAD));
        step(mk(0, 32'h0, 0, 0, 6'd0, 32'h0, GNT_NONE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
